// File: rtl/mesh_router_buffered.sv
// Generic single-clock FIFO: push/pop handshakes, registered count, pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push_rdy = !full from count only; pop_vld = !empty. Push+pop together holds the count.
module mesh_router_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// 5-port XY mesh router: per-input FIFO, per-output round-robin arbiter, 1-entry output register.
// Latency: flit accepted at edge t on an idle path is presented on its output after edge t+1.
// Backpressure: IN_READY = !fifo_full (no path from OUT_READY); a stalled output blocks only inputs whose head routes to it.
module mesh_router_buffered #(
    parameter int FLIT_W     = 18,
    parameter int COORD_W    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] X_IN,
    input  logic [COORD_W-1:0] Y_IN,
    input  logic [FLIT_W-1:0]  W_IN,
    input  logic [FLIT_W-1:0]  E_IN,
    input  logic [FLIT_W-1:0]  N_IN,
    input  logic [FLIT_W-1:0]  S_IN,
    input  logic [FLIT_W-1:0]  L_IN,
    input  logic               W_IN_VALID,
    input  logic               E_IN_VALID,
    input  logic               N_IN_VALID,
    input  logic               S_IN_VALID,
    input  logic               L_IN_VALID,
    output logic               W_IN_READY,
    output logic               E_IN_READY,
    output logic               N_IN_READY,
    output logic               S_IN_READY,
    output logic               L_IN_READY,
    output logic [FLIT_W-1:0]  W_OUT,
    output logic [FLIT_W-1:0]  E_OUT,
    output logic [FLIT_W-1:0]  N_OUT,
    output logic [FLIT_W-1:0]  S_OUT,
    output logic [FLIT_W-1:0]  L_OUT,
    output logic               W_OUT_VALID,
    output logic               E_OUT_VALID,
    output logic               N_OUT_VALID,
    output logic               S_OUT_VALID,
    output logic               L_OUT_VALID,
    input  logic               W_OUT_READY,
    input  logic               E_OUT_READY,
    input  logic               N_OUT_READY,
    input  logic               S_OUT_READY,
    input  logic               L_OUT_READY
);
    localparam int NP = 5;

    typedef enum logic [2:0] {P_W = 3'd0, P_E = 3'd1, P_N = 3'd2, P_S = 3'd3, P_L = 3'd4} port_e;

    typedef struct packed {
        logic [COORD_W-1:0]          dx;
        logic [COORD_W-1:0]          dy;
        logic [FLIT_W-2*COORD_W-1:0] payload;
    } flit_t;

    flit_t           in_dat    [NP];
    logic [NP-1:0]   in_vld;
    logic [NP-1:0]   in_rdy;
    logic [NP-1:0]   fifo_rdy;
    flit_t           head_dat  [NP];
    logic [NP-1:0]   head_vld;
    port_e           head_port [NP];
    logic [NP-1:0]   fifo_pop;
    logic [NP-1:0]   out_rdy;
    logic [NP-1:0]   loadable;
    logic [NP-1:0]   gnt_vld;
    logic [2:0]      gnt_idx   [NP];
    logic [2:0]      cand;
    logic [2:0]      rr_ptr    [NP];
    flit_t           out_dat_q [NP];
    logic [NP-1:0]   out_vld_q;

    // X is fully resolved before Y; unsigned compares, no mesh-bounds check.
    function automatic port_e xy_route(input flit_t f, input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        if (f.dx > x)      return P_E;
        else if (f.dx < x) return P_W;
        else if (f.dy > y) return P_N;
        else if (f.dy < y) return P_S;
        else               return P_L;
    endfunction

    function automatic logic [2:0] rr_add(input logic [2:0] base, input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, k};
        if (s >= 4'(NP)) s = s - 4'(NP);
        return s[2:0];
    endfunction

    assign in_dat[0] = W_IN;
    assign in_dat[1] = E_IN;
    assign in_dat[2] = N_IN;
    assign in_dat[3] = S_IN;
    assign in_dat[4] = L_IN;
    assign in_vld    = {L_IN_VALID, S_IN_VALID, N_IN_VALID, E_IN_VALID, W_IN_VALID};
    assign out_rdy   = {L_OUT_READY, S_OUT_READY, N_OUT_READY, E_OUT_READY, W_OUT_READY};

    // READY is forced low while reset is asserted.
    assign in_rdy     = fifo_rdy & {NP{rst}};
    assign W_IN_READY = in_rdy[0];
    assign E_IN_READY = in_rdy[1];
    assign N_IN_READY = in_rdy[2];
    assign S_IN_READY = in_rdy[3];
    assign L_IN_READY = in_rdy[4];

    for (genvar i = 0; i < NP; i++) begin : g_in
        mesh_router_fifo #(
            .W     (FLIT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push_vld (in_vld[i]),
            .push_rdy (fifo_rdy[i]),
            .push_dat (in_dat[i]),
            .pop_vld  (head_vld[i]),
            .pop_rdy  (fifo_pop[i]),
            .pop_dat  (head_dat[i])
        );
        assign head_port[i] = xy_route(head_dat[i], X_IN, Y_IN);
    end

    assign loadable = ~out_vld_q | out_rdy;

    // Scan requesters starting at the RR pointer; first hit wins.
    always_comb begin
        cand = '0;
        for (int o = 0; o < NP; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int k = 0; k < NP; k++) begin
                cand = rr_add(rr_ptr[o], 3'(k));
                if (!gnt_vld[o] && loadable[o] && head_vld[cand] && head_port[cand] == 3'(o)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = cand;
                end
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        for (int i = 0; i < NP; i++) begin
            for (int o = 0; o < NP; o++) begin
                if (gnt_vld[o] && gnt_idx[o] == 3'(i)) fifo_pop[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NP; o++) begin
                out_dat_q[o] <= '0;
                out_vld_q[o] <= 1'b0;
                rr_ptr[o]    <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (gnt_vld[o]) begin
                    out_dat_q[o] <= head_dat[gnt_idx[o]];
                    out_vld_q[o] <= 1'b1;
                    rr_ptr[o]    <= rr_add(gnt_idx[o], 3'd1);
                end else if (out_rdy[o]) begin
                    // Data holds its last value once accepted.
                    out_vld_q[o] <= 1'b0;
                end
            end
        end
    end

    assign W_OUT       = out_dat_q[0];
    assign E_OUT       = out_dat_q[1];
    assign N_OUT       = out_dat_q[2];
    assign S_OUT       = out_dat_q[3];
    assign L_OUT       = out_dat_q[4];
    assign W_OUT_VALID = out_vld_q[0];
    assign E_OUT_VALID = out_vld_q[1];
    assign N_OUT_VALID = out_vld_q[2];
    assign S_OUT_VALID = out_vld_q[3];
    assign L_OUT_VALID = out_vld_q[4];
endmodule

// File: tb/tb_mesh_router_buffered.sv
// Scoreboard bench for mesh_router_buffered: accepted flits are queued with their XY destination
// and matched, in per-source order, against flits leaving each output.
module tb_mesh_router_buffered;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  x_pos;
    logic [1:0]  y_pos;
    logic [17:0] in_dat  [5];
    logic        in_vld  [5];
    logic        in_rdy  [5];
    logic [17:0] out_dat [5];
    logic        out_vld [5];
    logic        out_rdy [5];

    typedef struct packed {
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [17:0] flit;
    } sb_t;

    sb_t sb_q[$];
    int  out_cnt [5];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  seq     = 1;

    always #5 clk = ~clk;

    mesh_router_buffered #(.FLIT_W(18), .COORD_W(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .X_IN(x_pos), .Y_IN(y_pos),
        .W_IN(in_dat[0]), .E_IN(in_dat[1]), .N_IN(in_dat[2]), .S_IN(in_dat[3]), .L_IN(in_dat[4]),
        .W_IN_VALID(in_vld[0]), .E_IN_VALID(in_vld[1]), .N_IN_VALID(in_vld[2]),
        .S_IN_VALID(in_vld[3]), .L_IN_VALID(in_vld[4]),
        .W_IN_READY(in_rdy[0]), .E_IN_READY(in_rdy[1]), .N_IN_READY(in_rdy[2]),
        .S_IN_READY(in_rdy[3]), .L_IN_READY(in_rdy[4]),
        .W_OUT(out_dat[0]), .E_OUT(out_dat[1]), .N_OUT(out_dat[2]), .S_OUT(out_dat[3]), .L_OUT(out_dat[4]),
        .W_OUT_VALID(out_vld[0]), .E_OUT_VALID(out_vld[1]), .N_OUT_VALID(out_vld[2]),
        .S_OUT_VALID(out_vld[3]), .L_OUT_VALID(out_vld[4]),
        .W_OUT_READY(out_rdy[0]), .E_OUT_READY(out_rdy[1]), .N_OUT_READY(out_rdy[2]),
        .S_OUT_READY(out_rdy[3]), .L_OUT_READY(out_rdy[4])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [2:0] src, input logic [10:0] sq);
        return {dx, dy, src, sq};
    endfunction

    // 0=W 1=E 2=N 3=S 4=L
    function automatic logic [2:0] ref_route(input logic [17:0] f, input logic [1:0] x, input logic [1:0] y);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = f[17:16];
        dy = f[15:14];
        if (dx > x) return 3'd1;
        if (dx < x) return 3'd0;
        if (dy > y) return 3'd2;
        if (dy < y) return 3'd3;
        return 3'd4;
    endfunction

    task automatic sb_match(input logic [2:0] o, input logic [17:0] f);
        int   hit;
        logic ooo;
        hit = -1;
        ooo = 1'b0;
        for (int j = 0; j < sb_q.size(); j++)
            if (hit < 0 && sb_q[j].dst == o && sb_q[j].flit == f) hit = j;
        check("sb_hit", 32'(hit >= 0), 32'd1);
        if (hit >= 0) begin
            for (int j = 0; j < hit; j++)
                if (sb_q[j].src == sb_q[hit].src && sb_q[j].dst == o) ooo = 1'b1;
            check("sb_order", 32'(ooo), 32'd0);
            sb_q.delete(hit);
        end
    endtask

    task automatic sb_sample();
        sb_t e;
        if (!rst) begin
            sb_q.delete();
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (in_vld[i] && in_rdy[i]) begin
                e.src  = 3'(i);
                e.dst  = ref_route(in_dat[i], x_pos, y_pos);
                e.flit = in_dat[i];
                sb_q.push_back(e);
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (out_vld[o] && out_rdy[o]) begin
                out_cnt[o]++;
                sb_match(3'(o), out_dat[o]);
            end
        end
    endtask

    task automatic sample_point();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] x, input logic [1:0] y);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) in_vld[i] = 1'b0;
        x_pos = x;
        y_pos = y;
        sb_q.delete();
        drive_point();
        drive_point();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int max);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < max) begin
            sample_point();
            drive_point();
            c++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        int          nr;
        logic [17:0] od;
        int          snap [5];
        int          sent;
        int          grants;
        int          per_src [5];
        logic [2:0]  exp_src;
        logic [2:0]  s;
        logic        acc;
        logic        acc_v [5];
        logic [17:0] first;
        logic [17:0] f;
        logic [1:0]  t2_dx [5] = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd1};
        logic [1:0]  t2_dy [5] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
        int          t2_po [5] = '{1, 0, 2, 3, 4};

        rst = 1'b1;
        x_pos = 2'd0;
        y_pos = 2'd0;
        for (int i = 0; i < 5; i++) begin
            in_vld[i] = 1'b0;
            in_dat[i] = '0;
            out_rdy[i] = 1'b1;
            out_cnt[i] = 0;
        end
        #1 rst = 1'b0;
        #2;
        nv = 0; nr = 0; od = '0;
        for (int i = 0; i < 5; i++) begin
            if (out_vld[i]) nv++;
            if (in_rdy[i]) nr++;
            od |= out_dat[i];
        end
        check("rst_out_vld", 32'(nv), 32'd0);
        check("rst_out_dat", 32'(od), 32'd0);
        check("rst_in_rdy", 32'(nr), 32'd0);

        // Single flit S -> W, latency and pulse width
        do_reset(2'd3, 2'd1);
        in_dat[3] = 18'h1a349;
        in_vld[3] = 1'b1;
        sample_point();
        check("t1_in_rdy", 32'(in_rdy[3]), 32'd1);
        drive_point();
        in_vld[3] = 1'b0;
        sample_point();
        check("t1_early", 32'(out_vld[0]), 32'd0);
        drive_point();
        sample_point();
        check("t1_w_vld", 32'(out_vld[0]), 32'd1);
        check("t1_w_dat", 32'(out_dat[0]), 32'h1a349);
        check("t1_others", 32'({out_vld[1], out_vld[2], out_vld[3], out_vld[4]}), 32'd0);
        drive_point();
        sample_point();
        check("t1_w_drop", 32'(out_vld[0]), 32'd0);
        drive_point();

        // Route sweep at (1,1)
        do_reset(2'd1, 2'd1);
        for (int t = 0; t < 5; t++) begin
            for (int o = 0; o < 5; o++) snap[o] = out_cnt[o];
            in_dat[4] = mk(t2_dx[t], t2_dy[t], 3'd4, 11'(seq));
            seq++;
            in_vld[4] = 1'b1;
            sample_point();
            drive_point();
            in_vld[4] = 1'b0;
            drain("t2_drain", 10);
            for (int o = 0; o < 5; o++)
                check("t2_port_cnt", 32'(out_cnt[o] - snap[o]), (o == t2_po[t]) ? 32'd1 : 32'd0);
        end

        // All five inputs contend for L
        do_reset(2'd1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            in_dat[i] = mk(2'd1, 2'd1, 3'(i), 11'(seq));
            seq++;
            in_vld[i] = 1'b1;
            per_src[i] = 0;
        end
        exp_src = 3'd0;
        grants = 0;
        for (int c = 0; c < 60 && grants < 20; c++) begin
            sample_point();
            if (out_vld[4] && out_rdy[4]) begin
                s = out_dat[4][13:11];
                check("t3_rr_src", 32'(s), 32'(exp_src));
                exp_src = (exp_src == 3'd4) ? 3'd0 : exp_src + 3'd1;
                if (s < 3'd5) per_src[s]++;
                grants++;
            end
            for (int i = 0; i < 5; i++) acc_v[i] = in_vld[i] && in_rdy[i];
            drive_point();
            for (int i = 0; i < 5; i++) begin
                if (acc_v[i]) begin
                    in_dat[i] = mk(2'd1, 2'd1, 3'(i), 11'(seq));
                    seq++;
                end
            end
        end
        check("t3_grants", 32'(grants), 32'd20);
        for (int i = 0; i < 5; i++) check("t3_share", 32'(per_src[i]), 32'd4);
        for (int i = 0; i < 5; i++) in_vld[i] = 1'b0;
        drain("t3_drain", 60);

        // E stalled, W streams 6 flits east
        do_reset(2'd1, 2'd1);
        out_rdy[1] = 1'b0;
        first = mk(2'd3, 2'd1, 3'd0, 11'(seq));
        seq++;
        in_dat[0] = first;
        in_vld[0] = 1'b1;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            sample_point();
            acc = in_vld[0] && in_rdy[0];
            if (acc) sent++;
            if (out_vld[1]) check("t4_hold", 32'(out_dat[1]), 32'(first));
            drive_point();
            if (acc) begin
                if (sent < 6) begin
                    in_dat[0] = mk(2'd3, 2'd1, 3'd0, 11'(seq));
                    seq++;
                end else begin
                    in_vld[0] = 1'b0;
                end
            end
        end
        check("t4_accepts", 32'(sent), 32'd5);
        check("t4_w_rdy", 32'(in_rdy[0]), 32'd0);
        check("t4_e_vld", 32'(out_vld[1]), 32'd1);

        // N -> L proceeds while E is blocked
        f = mk(2'd1, 2'd1, 3'd2, 11'(seq));
        seq++;
        in_dat[2] = f;
        in_vld[2] = 1'b1;
        sample_point();
        check("t5_n_rdy", 32'(in_rdy[2]), 32'd1);
        drive_point();
        in_vld[2] = 1'b0;
        sample_point();
        check("t5_l_early", 32'(out_vld[4]), 32'd0);
        drive_point();
        sample_point();
        check("t5_l_vld", 32'(out_vld[4]), 32'd1);
        check("t5_l_dat", 32'(out_dat[4]), 32'(f));
        check("t5_e_still", 32'(out_dat[1]), 32'(first));
        drive_point();

        snap[1] = out_cnt[1];
        out_rdy[1] = 1'b1;
        for (int c = 0; c < 30 && (sb_q.size() != 0 || in_vld[0]); c++) begin
            sample_point();
            acc = in_vld[0] && in_rdy[0];
            drive_point();
            if (acc) in_vld[0] = 1'b0;
        end
        check("t4_e_count", 32'(out_cnt[1] - snap[1]), 32'd6);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset with FIFOs part-full and outputs valid
        out_rdy[1] = 1'b0;
        out_rdy[3] = 1'b0;
        in_vld[0] = 1'b1;
        in_dat[0] = mk(2'd2, 2'd1, 3'd0, 11'(seq));
        seq++;
        in_vld[2] = 1'b1;
        in_dat[2] = mk(2'd1, 2'd0, 3'd2, 11'(seq));
        seq++;
        for (int c = 0; c < 4; c++) begin
            sample_point();
            for (int i = 0; i < 5; i++) acc_v[i] = in_vld[i] && in_rdy[i];
            drive_point();
            if (acc_v[0]) begin
                in_dat[0] = mk(2'd2, 2'd1, 3'd0, 11'(seq));
                seq++;
            end
            if (acc_v[2]) begin
                in_dat[2] = mk(2'd1, 2'd0, 3'd2, 11'(seq));
                seq++;
            end
        end
        check("t6_pre_e_vld", 32'(out_vld[1]), 32'd1);
        check("t6_pre_s_vld", 32'(out_vld[3]), 32'd1);
        #2 rst = 1'b0;
        #1;
        nv = 0; nr = 0; od = '0;
        for (int i = 0; i < 5; i++) begin
            if (out_vld[i]) nv++;
            if (in_rdy[i]) nr++;
            od |= out_dat[i];
        end
        check("t6_out_vld", 32'(nv), 32'd0);
        check("t6_out_dat", 32'(od), 32'd0);
        check("t6_in_rdy", 32'(nr), 32'd0);
        sb_q.delete();
        for (int i = 0; i < 5; i++) begin
            in_vld[i] = 1'b0;
            out_rdy[i] = 1'b1;
        end
        sample_point();
        drive_point();
        drive_point();
        rst = 1'b1;
        for (int o = 0; o < 5; o++) snap[o] = out_cnt[o];
        for (int c = 0; c < 6; c++) begin
            sample_point();
            drive_point();
        end
        nv = 0;
        for (int o = 0; o < 5; o++) nv += out_cnt[o] - snap[o];
        check("t6_no_stale", 32'(nv), 32'd0);
        f = mk(2'd0, 2'd1, 3'd4, 11'(seq));
        seq++;
        in_dat[4] = f;
        in_vld[4] = 1'b1;
        sample_point();
        drive_point();
        in_vld[4] = 1'b0;
        sample_point();
        check("t6_w_early", 32'(out_vld[0]), 32'd0);
        drive_point();
        sample_point();
        check("t6_w_vld", 32'(out_vld[0]), 32'd1);
        check("t6_w_dat", 32'(out_dat[0]), 32'(f));
        drive_point();
        drain("t6_drain", 10);

        check("end_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
